// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between display and CPU.
// Display wins by default; a wait counter forces a stalled CPU through.
module vram_arbiter #(
  parameter int ADDRW      = 16,
  parameter int DATAW      = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [ADDRW-1:0] disp_addr,
  output logic             disp_rvalid,
  output logic [DATAW-1:0] disp_rdata,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_we,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [DATAW-1:0] cpu_wdata,
  output logic             cpu_rvalid,
  output logic [DATAW-1:0] cpu_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_din,
  input  logic [DATAW-1:0] mem_dout,
  output logic             starve_event
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_CPU
  } own_t;

  localparam logic [7:0] SAT = 8'(STARVE_MAX);

  logic [7:0] wait_cnt;
  own_t       tag1;
  own_t       tag2;
  logic       ovr;
  logic       ovr_go;
  logic       disp_go;
  logic       cpu_go;
  logic       disp_hs;
  logic       cpu_hs;

  // Override is armed once the CPU has waited the full budget.
  assign ovr     = (STARVE_MAX != 0) && (wait_cnt == SAT);
  assign ovr_go  = rst_n && ovr && cpu_valid;
  assign disp_go = rst_n && !ovr_go && disp_valid;
  assign cpu_go  = rst_n && !ovr_go && !disp_valid && cpu_valid;

  assign disp_hs = disp_valid && disp_ready;
  assign cpu_hs  = cpu_valid && cpu_ready;

  // Mutually exclusive grant decode; at most one ready per cycle.
  always_comb begin
    disp_ready   = 1'b0;
    cpu_ready    = 1'b0;
    starve_event = 1'b0;
    unique case (1'b1)
      ovr_go: begin
        cpu_ready    = 1'b1;
        starve_event = 1'b1;
      end
      disp_go: disp_ready = 1'b1;
      cpu_go:  cpu_ready  = 1'b1;
      default: ;
    endcase
  end

  // CPU wait counter: counts stalled cycles, saturates at the budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (cpu_hs || !cpu_valid) begin
      wait_cnt <= '0;
    end else if (wait_cnt != SAT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Registered memory command for the winner of this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_en   <= disp_hs || cpu_hs;
      mem_we   <= cpu_hs && cpu_we;
      mem_addr <= cpu_hs ? cpu_addr : disp_addr;
      mem_din  <= cpu_wdata;
    end
  end

  // Owner tags follow reads so mem_dout lands in the right port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag1        <= OWN_NONE;
      tag2        <= OWN_NONE;
      disp_rvalid <= 1'b0;
      cpu_rvalid  <= 1'b0;
      disp_rdata  <= '0;
      cpu_rdata   <= '0;
    end else begin
      if (disp_hs) begin
        tag1 <= OWN_DISP;
      end else if (cpu_hs && !cpu_we) begin
        tag1 <= OWN_CPU;
      end else begin
        tag1 <= OWN_NONE;
      end
      tag2        <= tag1;
      disp_rvalid <= (tag2 == OWN_DISP);
      cpu_rvalid  <= (tag2 == OWN_CPU);
      if (tag2 == OWN_DISP) begin
        disp_rdata <= mem_dout;
      end
      if (tag2 == OWN_CPU) begin
        cpu_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized and directed checks of vram_arbiter
// against a queue-based reference model and a behavioural VRAM.
module tb_vram_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          disp_valid = 1'b0;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;

  logic          disp_ready, disp_rvalid, cpu_ready, cpu_rvalid;
  logic [DW-1:0] disp_rdata, cpu_rdata, mem_din, mem_dout;
  logic          mem_en, mem_we, starve_event;
  logic [AW-1:0] mem_addr;

  logic          d0_disp_ready, d0_disp_rvalid, d0_cpu_ready, d0_cpu_rvalid;
  logic [DW-1:0] d0_disp_rdata, d0_cpu_rdata, d0_mem_din, d0_mem_dout;
  logic          d0_mem_en, d0_mem_we, d0_starve;
  logic [AW-1:0] d0_mem_addr;

  int n_tests = 0;
  int n_fail = 0;

  vram_arbiter #(.ADDRW(AW), .DATAW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .starve_event(starve_event)
  );

  vram_arbiter #(.ADDRW(AW), .DATAW(DW), .STARVE_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(d0_disp_ready),
    .disp_addr(disp_addr), .disp_rvalid(d0_disp_rvalid),
    .disp_rdata(d0_disp_rdata),
    .cpu_valid(cpu_valid), .cpu_ready(d0_cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rvalid(d0_cpu_rvalid), .cpu_rdata(d0_cpu_rdata),
    .mem_en(d0_mem_en), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
    .mem_din(d0_mem_din), .mem_dout(d0_mem_dout),
    .starve_event(d0_starve)
  );

  function automatic logic [15:0] init_val(int i);
    if (i == 16) return 16'hABCD;
    return 16'(i * 37 + 4660);
  endfunction

  // Behavioural VRAMs, preloaded on the first clock edge.
  logic [DW-1:0] vram [256];
  logic [DW-1:0] vram0 [256];
  bit ld = 1'b0;
  always @(posedge clk) begin
    if (!ld) begin
      for (int i = 0; i < 256; i++) begin
        vram[i] = init_val(i);
        vram0[i] = init_val(i);
      end
      ld = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) vram[mem_addr[7:0]] = mem_din;
      else mem_dout <= vram[mem_addr[7:0]];
    end
    if (d0_mem_en) begin
      if (d0_mem_we) vram0[d0_mem_addr[7:0]] = d0_mem_din;
      else d0_mem_dout <= vram0[d0_mem_addr[7:0]];
    end
  end

  // Reference model for the STARVE_MAX=8 instance.
  typedef struct {
    int          due;
    bit          cpu;
    logic [15:0] data;
  } ret_t;

  int            cyc = 0;
  int            m_wait = 0;
  logic          m_men = 0, m_mwe = 0, m_drv = 0, m_crv = 0;
  logic [15:0]   m_maddr = 0, m_mdin = 0, m_drd = 0, m_crd = 0;
  logic [15:0]   ref_mem [256];
  bit            m_ld = 1'b0;
  ret_t          rq[$];

  function automatic logic [1:0] grant(int w, logic rn, logic dv,
                                       logic cv);
    if (!rn) return 2'b00;
    if (SMAX > 0 && w >= SMAX && cv) return 2'b10;
    if (dv) return 2'b01;
    if (cv) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [1:0] g;
    ret_t r;
    if (!m_ld) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      m_ld = 1'b1;
    end
    g = grant(m_wait, rst_n, disp_valid, cpu_valid);
    m_drv = 1'b0;
    m_crv = 1'b0;
    if (!rst_n) begin
      m_wait = 0;
      rq.delete();
      m_men = 0; m_mwe = 0; m_maddr = 0; m_mdin = 0;
      m_drd = 0; m_crd = 0;
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc + 1) begin
        r = rq.pop_front();
        if (r.cpu) begin m_crv = 1'b1; m_crd = r.data; end
        else begin m_drv = 1'b1; m_drd = r.data; end
      end
      m_men = (g != 2'b00);
      m_mwe = g[1] && cpu_we;
      m_maddr = g[1] ? cpu_addr : disp_addr;
      m_mdin = cpu_wdata;
      if (g[0])
        rq.push_back(ret_t'{cyc + 3, 1'b0, ref_mem[disp_addr[7:0]]});
      if (g[1] && !cpu_we)
        rq.push_back(ret_t'{cyc + 3, 1'b1, ref_mem[cpu_addr[7:0]]});
      if (g[1] && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      if (g[1] || !cpu_valid) m_wait = 0;
      else if (m_wait < SMAX) m_wait++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    disp_valid = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0;
    disp_addr = 16'h0010; cpu_addr = 16'h0020;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({disp_ready, cpu_ready, disp_rvalid, cpu_rvalid, mem_en,
           starve_event, disp_rdata, cpu_rdata} !== 38'd0) begin
        n_fail++;
        $display("FAIL reset_outs: got %b/%h/%h want all zero",
                 {disp_ready, cpu_ready, disp_rvalid, cpu_rvalid, mem_en,
                  starve_event}, disp_rdata, cpu_rdata);
      end
      tick();
    end
    rst_n = 1'b1; cpu_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (disp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL first_ready: got %b want 1", disp_ready);
    end
    tick();
    disp_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      n_fail++;
      $display("FAIL first_cmd: got %b%b %h want 1 0 0010",
               mem_en, mem_we, mem_addr);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (disp_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_rvalid: got %b want 0", disp_rvalid);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({disp_rvalid, disp_rdata} !== {1'b1, 16'hABCD}) begin
      n_fail++;
      $display("FAIL first_rdata: got %b %h want 1 abcd",
               disp_rvalid, disp_rdata);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({disp_rvalid, disp_rdata} !== {1'b0, 16'hABCD}) begin
      n_fail++;
      $display("FAIL rdata_hold: got %b %h want 0 abcd",
               disp_rvalid, disp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] wd [4];
    int idx;
    for (int i = 0; i < 4; i++) wd[i] = 16'($urandom);
    disp_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cpu_valid = (k < 8);
      cpu_we = (k < 4);
      cpu_addr = 16'(k % 4);
      cpu_wdata = wd[k % 4];
      @(negedge clk);
      n_tests++;
      if (cpu_ready !== (k < 8)) begin
        n_fail++;
        $display("FAIL b2b_ready k=%0d: got %b want %b", k, cpu_ready,
                 (k < 8));
      end
      n_tests++;
      if (mem_en !== (k >= 1 && k <= 8)) begin
        n_fail++;
        $display("FAIL b2b_en k=%0d: got %b want %b", k, mem_en,
                 (k >= 1 && k <= 8));
      end
      if (k >= 1 && k <= 8) begin
        n_tests++;
        if ({mem_we, mem_addr} !== {(k <= 4), 16'((k - 1) % 4)}) begin
          n_fail++;
          $display("FAIL b2b_cmd k=%0d: got %b %h want %b %h", k, mem_we,
                   mem_addr, (k <= 4), 16'((k - 1) % 4));
        end
      end
      if (k >= 1 && k <= 4) begin
        n_tests++;
        if (mem_din !== wd[k - 1]) begin
          n_fail++;
          $display("FAIL b2b_din k=%0d: got %h want %h", k, mem_din,
                   wd[k - 1]);
        end
      end
      n_tests++;
      if (cpu_rvalid !== (k >= 7 && k <= 10)) begin
        n_fail++;
        $display("FAIL b2b_rvalid k=%0d: got %b want %b", k, cpu_rvalid,
                 (k >= 7 && k <= 10));
      end
      if (k >= 7) begin
        idx = ((k > 10) ? 10 : k) - 7;
        n_tests++;
        if (cpu_rdata !== wd[idx]) begin
          n_fail++;
          $display("FAIL b2b_rdata k=%0d: got %h want %h", k, cpu_rdata,
                   wd[idx]);
        end
      end
      tick();
    end
  endtask

  task automatic test_starve();
    logic [2:0] exp;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00A0;
    disp_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      disp_addr = 16'($urandom_range(0, 255));
      if (k == 10) cpu_addr = 16'h00A1;
      @(negedge clk);
      exp = (k == 9 || k == 18) ? 3'b011 : 3'b100;
      n_tests++;
      if ({disp_ready, cpu_ready, starve_event} !== exp) begin
        n_fail++;
        $display("FAIL starve_grant k=%0d: got %b want %b", k,
                 {disp_ready, cpu_ready, starve_event}, exp);
      end
      n_tests++;
      if (cpu_rvalid !== (k == 12)) begin
        n_fail++;
        $display("FAIL starve_rvalid k=%0d: got %b want %b", k,
                 cpu_rvalid, (k == 12));
      end
      if (k == 12) begin
        n_tests++;
        if (cpu_rdata !== init_val(160)) begin
          n_fail++;
          $display("FAIL starve_rdata: got %h want %h", cpu_rdata,
                   init_val(160));
        end
      end
      tick();
    end
    cpu_valid = 1'b0;
    disp_valid = 1'b0;
  endtask

  task automatic test_strict();
    disp_valid = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0;
    cpu_addr = 16'h0055;
    for (int k = 0; k < 50; k++) begin
      disp_addr = 16'($urandom_range(0, 255));
      @(negedge clk);
      n_tests++;
      if ({d0_disp_ready, d0_cpu_ready, d0_starve} !== 3'b100) begin
        n_fail++;
        $display("FAIL strict_grant k=%0d: got %b want 100", k,
                 {d0_disp_ready, d0_cpu_ready, d0_starve});
      end
      tick();
    end
    disp_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({d0_disp_ready, d0_cpu_ready, d0_starve} !== 3'b010) begin
      n_fail++;
      $display("FAIL strict_release: got %b want 010",
               {d0_disp_ready, d0_cpu_ready, d0_starve});
    end
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    disp_valid = 1'b0; cpu_valid = 1'b1; cpu_we = 1'b0;
    cpu_addr = 16'h00C3;
    @(negedge clk);
    n_tests++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_hs: got %b want 1", cpu_ready);
    end
    tick();
    cpu_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_flushed k=%0d: got %b want 0", k, cpu_rvalid);
      end
      tick();
    end
    cpu_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rehs: got %b want 1", cpu_ready);
    end
    tick();
    cpu_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, init_val(195)}) begin
      n_fail++;
      $display("FAIL mid_reread: got %b %h want 1 %h", cpu_rvalid,
               cpu_rdata, init_val(195));
    end
    tick();
  endtask

  task automatic test_interleaved();
    logic dp, cp, est;
    logic [1:0] g;
    int dq[$], cq[$];
    int lat;
    dp = 1'b0; cp = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!dp && $urandom_range(0, 4) != 0) begin
        dp = 1'b1;
        disp_addr = 16'($urandom_range(0, 255));
      end
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 255));
        cpu_wdata = 16'($urandom);
      end
      disp_valid = dp;
      cpu_valid = cp;
      @(negedge clk);
      g = grant(m_wait, rst_n, disp_valid, cpu_valid);
      est = (m_wait >= SMAX) && cpu_valid;
      n_tests++;
      if ({disp_ready, cpu_ready, starve_event} !== {g[0], g[1], est}) begin
        n_fail++;
        $display("FAIL il_grant k=%0d: got %b want %b", k,
                 {disp_ready, cpu_ready, starve_event}, {g[0], g[1], est});
      end
      n_tests++;
      if ({disp_rvalid, cpu_rvalid, disp_rdata, cpu_rdata} !==
          {m_drv, m_crv, m_drd, m_crd}) begin
        n_fail++;
        $display("FAIL il_ret k=%0d: got %b%b %h %h want %b%b %h %h", k,
                 disp_rvalid, cpu_rvalid, disp_rdata, cpu_rdata,
                 m_drv, m_crv, m_drd, m_crd);
      end
      n_tests++;
      if (mem_en !== m_men ||
          (m_men && {mem_we, mem_addr} !== {m_mwe, m_maddr}) ||
          (m_men && m_mwe && mem_din !== m_mdin)) begin
        n_fail++;
        $display("FAIL il_cmd k=%0d: got %b%b %h %h want %b%b %h %h", k,
                 mem_en, mem_we, mem_addr, mem_din,
                 m_men, m_mwe, m_maddr, m_mdin);
      end
      if (disp_rvalid) begin
        lat = (dq.size() > 0) ? cyc - dq.pop_front() : -1;
        n_tests++;
        if (lat != 3) begin
          n_fail++;
          $display("FAIL il_dlat k=%0d: got %0d want 3", k, lat);
        end
      end
      if (cpu_rvalid) begin
        lat = (cq.size() > 0) ? cyc - cq.pop_front() : -1;
        n_tests++;
        if (lat != 3) begin
          n_fail++;
          $display("FAIL il_clat k=%0d: got %0d want 3", k, lat);
        end
      end
      if (disp_valid && disp_ready) begin
        dq.push_back(cyc);
        dp = 1'b0;
      end
      if (cpu_valid && cpu_ready) begin
        if (!cpu_we) cq.push_back(cyc);
        cp = 1'b0;
      end
      tick();
    end
    disp_valid = 1'b0;
    cpu_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_starve();
    test_strict();
    test_reset_mid();
    test_interleaved();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
